// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS-subset control sequencer. It steps instructions through FETCH/DECODE/EXECUTE/MEM/WB over one shared memory port.
// Each mem_ready=0 cycle in FETCH, MEM_READ or MEM_WRITE holds the state for one cycle. Cycle and retired-instruction counters saturate.
module mc_control_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             enable,
    input  logic [5:0]       opcode,
    input  logic             zero_flag,
    input  logic             mem_ready,
    input  logic             clr_cnt,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_2_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic [3:0]       state,
    output logic             instr_retired,
    output logic             illegal_op,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXECUTE   = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_ADDI_EX   = 4'd11,
        S_ADDI_WB   = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    state_e           term_state;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

    // zero_flag is qualified in the datapath together with pc_write_cond.
    logic unused_zero_flag;
    assign unused_zero_flag = zero_flag;

    // Dropping enable only takes effect at an instruction boundary.
    assign term_state = enable ? S_FETCH : S_IDLE;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= S_IDLE;
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (enable) state_d = S_FETCH;
            S_FETCH:     if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    default:      state_d = term_state;
                endcase
            end
            S_MEM_ADDR: begin
                if (opcode == OP_LW)      state_d = S_MEM_READ;
                else if (opcode == OP_SW) state_d = S_MEM_WRITE;
                else                      state_d = term_state;
            end
            S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WRITE: if (mem_ready) state_d = term_state;
            S_EXECUTE:   state_d = S_ALU_WB;
            S_ADDI_EX:   state_d = S_ADDI_WB;
            S_MEM_WB, S_ALU_WB, S_ADDI_WB, S_BRANCH, S_JUMP:
                         state_d = term_state;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_2_reg     = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        instr_retired = 1'b0;
        illegal_op    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: illegal_op = 1'b0;
                    default:                                       illegal_op = 1'b1;
                endcase
            end
            S_MEM_ADDR, S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write     = 1'b1;
                mem_2_reg     = 1'b1;
                instr_retired = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write     = 1'b1;
                i_or_d        = 1'b1;
                instr_retired = mem_ready;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_ALU_WB: begin
                reg_write     = 1'b1;
                reg_dst       = 1'b1;
                instr_retired = 1'b1;
            end
            S_ADDI_WB: begin
                reg_write     = 1'b1;
                instr_retired = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                instr_retired = 1'b1;
            end
            S_JUMP: begin
                pc_write      = 1'b1;
                pc_source     = 2'b10;
                instr_retired = 1'b1;
            end
            default: ;
        endcase
    end

    // Clear beats increment, so a retire coinciding with clr_cnt is dropped.
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        instr_cnt_d = instr_cnt_q;
        if (clr_cnt) begin
            cycle_cnt_d = '0;
            instr_cnt_d = '0;
        end else begin
            if ((state_q != S_IDLE) && (cycle_cnt_q != CNT_MAX))
                cycle_cnt_d = cycle_cnt_q + CNT_ONE;
            if (instr_retired && (instr_cnt_q != CNT_MAX))
                instr_cnt_d = instr_cnt_q + CNT_ONE;
        end
    end

    assign state     = state_q;
    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: per-cycle vector table plus hand sequences for reset and saturation.
module tb_mc_control_fsm;

    logic        clk;
    logic        arst;
    logic        enable;
    logic [5:0]  opcode;
    logic        zero_flag;
    logic        mem_ready;
    logic        clr_cnt;

    logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic        mem_2_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [3:0]  state;
    logic        instr_retired, illegal_op;
    logic [31:0] cycle_cnt, instr_cnt;

    logic        unused_s_pcw, unused_s_pwc, unused_s_iod, unused_s_mrd, unused_s_mwr, unused_s_irw;
    logic        unused_s_m2r, unused_s_rdst, unused_s_rwr, unused_s_asa, unused_s_ret, unused_s_ill;
    logic [1:0]  unused_s_asb, unused_s_aop, unused_s_psrc;
    logic [3:0]  s_state;
    logic [3:0]  s_cycle_cnt, s_instr_cnt;

    logic [17:0] ctrl;
    assign ctrl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                   mem_2_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                   pc_source, instr_retired, illegal_op};

    // {pcw,pwc,iod,mrd,mwr,irw,m2r,rdst,rwr,asa,asb[2],aop[2],psrc[2],ret,ill}
    localparam logic [17:0] K_ZERO     = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] K_FETCH_R  = 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
    localparam logic [17:0] K_FETCH_W  = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
    localparam logic [17:0] K_DECODE   = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
    localparam logic [17:0] K_DEC_ILL  = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_1;
    localparam logic [17:0] K_ADDR     = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
    localparam logic [17:0] K_MRD      = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] K_MEMWB    = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_1_0;
    localparam logic [17:0] K_MWR_W    = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] K_MWR_R    = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_1_0;
    localparam logic [17:0] K_EXEC     = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
    localparam logic [17:0] K_ALUWB    = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_1_0;
    localparam logic [17:0] K_ADDIWB   = 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_1_0;
    localparam logic [17:0] K_BRANCH   = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_1_0;
    localparam logic [17:0] K_JUMP     = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_1_0;

    mc_control_fsm #(.CNT_W(32)) dut (
        .clk(clk), .arst(arst), .enable(enable), .opcode(opcode), .zero_flag(zero_flag),
        .mem_ready(mem_ready), .clr_cnt(clr_cnt),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_2_reg(mem_2_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .state(state), .instr_retired(instr_retired),
        .illegal_op(illegal_op), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
    );

    mc_control_fsm #(.CNT_W(4)) dut_small (
        .clk(clk), .arst(arst), .enable(enable), .opcode(opcode), .zero_flag(zero_flag),
        .mem_ready(mem_ready), .clr_cnt(clr_cnt),
        .pc_write(unused_s_pcw), .pc_write_cond(unused_s_pwc), .i_or_d(unused_s_iod),
        .mem_read(unused_s_mrd), .mem_write(unused_s_mwr), .ir_write(unused_s_irw),
        .mem_2_reg(unused_s_m2r), .reg_dst(unused_s_rdst), .reg_write(unused_s_rwr),
        .alu_src_a(unused_s_asa), .alu_src_b(unused_s_asb), .alu_op(unused_s_aop),
        .pc_source(unused_s_psrc), .state(s_state), .instr_retired(unused_s_ret),
        .illegal_op(unused_s_ill), .cycle_cnt(s_cycle_cnt), .instr_cnt(s_instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [5:0]  op;
        logic        rdy;
        logic        clr;
        logic [3:0]  st;
        logic [17:0] ctl;
        logic [31:0] cyc;
        logic [31:0] ins;
    } vec_t;

    vec_t vecs[$];
    int   total;
    int   bad;

    function automatic void add(input logic en, input logic [5:0] op, input logic rdy,
                                input logic clr, input logic [3:0] st, input logic [17:0] ctl,
                                input logic [31:0] cyc, input logic [31:0] ins);
        vec_t v;
        v.en = en; v.op = op; v.rdy = rdy; v.clr = clr;
        v.st = st; v.ctl = ctl; v.cyc = cyc; v.ins = ins;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        total = 0;
        bad   = 0;
        arst = 1'b1; enable = 1'b0; opcode = 6'h00; zero_flag = 1'b0;
        mem_ready = 1'b0; clr_cnt = 1'b0;

        // R-type, zero wait
        add(1, 6'h00, 1, 0, 4'd0,  K_ZERO,     0, 0);
        add(1, 6'h00, 1, 0, 4'd1,  K_FETCH_R,  0, 0);
        add(1, 6'h00, 1, 0, 4'd2,  K_DECODE,   1, 0);
        add(1, 6'h00, 1, 0, 4'd7,  K_EXEC,     2, 0);
        add(1, 6'h00, 1, 0, 4'd8,  K_ALUWB,    3, 0);
        // lw: 2 wait cycles in FETCH, 3 in MEM_READ
        add(1, 6'h23, 0, 0, 4'd1,  K_FETCH_W,  4, 1);
        add(1, 6'h23, 0, 0, 4'd1,  K_FETCH_W,  5, 1);
        add(1, 6'h23, 1, 0, 4'd1,  K_FETCH_R,  6, 1);
        add(1, 6'h23, 1, 0, 4'd2,  K_DECODE,   7, 1);
        add(1, 6'h23, 1, 0, 4'd3,  K_ADDR,     8, 1);
        add(1, 6'h23, 0, 0, 4'd4,  K_MRD,      9, 1);
        add(1, 6'h23, 0, 0, 4'd4,  K_MRD,     10, 1);
        add(1, 6'h23, 0, 0, 4'd4,  K_MRD,     11, 1);
        add(1, 6'h23, 1, 0, 4'd4,  K_MRD,     12, 1);
        add(1, 6'h23, 1, 0, 4'd5,  K_MEMWB,   13, 1);
        // beq
        add(1, 6'h04, 1, 0, 4'd1,  K_FETCH_R, 14, 2);
        add(1, 6'h04, 1, 0, 4'd2,  K_DECODE,  15, 2);
        add(1, 6'h04, 1, 0, 4'd9,  K_BRANCH,  16, 2);
        // j
        add(1, 6'h02, 1, 0, 4'd1,  K_FETCH_R, 17, 3);
        add(1, 6'h02, 1, 0, 4'd2,  K_DECODE,  18, 3);
        add(1, 6'h02, 1, 0, 4'd10, K_JUMP,    19, 3);
        // addi
        add(1, 6'h08, 1, 0, 4'd1,  K_FETCH_R, 20, 4);
        add(1, 6'h08, 1, 0, 4'd2,  K_DECODE,  21, 4);
        add(1, 6'h08, 1, 0, 4'd11, K_ADDR,    22, 4);
        add(1, 6'h08, 1, 0, 4'd12, K_ADDIWB,  23, 4);
        // illegal opcode
        add(1, 6'h3F, 1, 0, 4'd1,  K_FETCH_R, 24, 5);
        add(1, 6'h3F, 1, 0, 4'd2,  K_DEC_ILL, 25, 5);
        // sw with enable dropped during the write wait
        add(1, 6'h2B, 1, 0, 4'd1,  K_FETCH_R, 26, 5);
        add(1, 6'h2B, 1, 0, 4'd2,  K_DECODE,  27, 5);
        add(1, 6'h2B, 1, 0, 4'd3,  K_ADDR,    28, 5);
        add(0, 6'h2B, 0, 0, 4'd6,  K_MWR_W,   29, 5);
        add(0, 6'h2B, 0, 0, 4'd6,  K_MWR_W,   30, 5);
        add(0, 6'h2B, 1, 0, 4'd6,  K_MWR_R,   31, 5);
        add(0, 6'h2B, 1, 0, 4'd0,  K_ZERO,    32, 6);
        add(0, 6'h2B, 1, 0, 4'd0,  K_ZERO,    32, 6);
        add(0, 6'h00, 0, 1, 4'd0,  K_ZERO,    32, 6);
        add(0, 6'h00, 0, 0, 4'd0,  K_ZERO,     0, 0);

        #3;
        chk("reset state", 32'(state), 32'd0);
        chk("reset ctrl", 32'(ctrl), 32'd0);
        chk("reset cycle_cnt", cycle_cnt, 32'd0);
        chk("reset instr_cnt", instr_cnt, 32'd0);
        step();
        arst = 1'b0;

        foreach (vecs[i]) begin
            enable    = vecs[i].en;
            opcode    = vecs[i].op;
            mem_ready = vecs[i].rdy;
            clr_cnt   = vecs[i].clr;
            @(negedge clk);
            chk($sformatf("v%0d state", i), 32'(state), 32'(vecs[i].st));
            chk($sformatf("v%0d ctrl", i), 32'(ctrl), 32'(vecs[i].ctl));
            chk($sformatf("v%0d cycle_cnt", i), cycle_cnt, vecs[i].cyc);
            chk($sformatf("v%0d instr_cnt", i), instr_cnt, vecs[i].ins);
            step();
        end

        // Reset in the middle of a MEM_READ wait
        clr_cnt = 1'b0; enable = 1'b1; opcode = 6'h23; mem_ready = 1'b1;
        step();
        step();
        step();
        mem_ready = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("rdwait state", 32'(state), 32'd4);
        chk("rdwait ctrl", 32'(ctrl), 32'(K_MRD));
        chk("rdwait cycle_cnt", cycle_cnt, 32'd4);
        #1 arst = 1'b1;
        #1;
        chk("arst state", 32'(state), 32'd0);
        chk("arst ctrl", 32'(ctrl), 32'd0);
        chk("arst cycle_cnt", cycle_cnt, 32'd0);
        chk("arst instr_cnt", instr_cnt, 32'd0);
        mem_ready = 1'b1;
        step();
        chk("arst held state", 32'(state), 32'd0);
        chk("arst held retire", 32'(instr_retired), 32'd0);
        arst = 1'b0; enable = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        chk("post arst state", 32'(state), 32'd0);
        chk("post arst instr_cnt", instr_cnt, 32'd0);

        // Saturation with CNT_W=4 on a continuous R-type stream
        step();
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0; enable = 1'b1; opcode = 6'h00; mem_ready = 1'b1;
        repeat (81) step();
        @(negedge clk);
        chk("sat small state", 32'(s_state), 32'd1);
        chk("sat small cycle_cnt", 32'(s_cycle_cnt), 32'd15);
        chk("sat small instr_cnt", 32'(s_instr_cnt), 32'd15);
        chk("stream cycle_cnt", cycle_cnt, 32'd80);
        chk("stream instr_cnt", instr_cnt, 32'd20);
        step();
        @(negedge clk);
        chk("sat hold cycle_cnt", 32'(s_cycle_cnt), 32'd15);
        chk("sat hold instr_cnt", 32'(s_instr_cnt), 32'd15);
        chk("stream2 cycle_cnt", cycle_cnt, 32'd81);
        step();
        for (int k = 0; k < 8; k++) begin
            if (state != 4'd8) step();
        end
        chk("reach ALU_WB", 32'(state), 32'd8);
        clr_cnt = 1'b1;
        @(negedge clk);
        chk("clr cycle retire", 32'(instr_retired), 32'd1);
        step();
        clr_cnt = 1'b0;
        @(negedge clk);
        chk("clr small cycle_cnt", 32'(s_cycle_cnt), 32'd0);
        chk("clr small instr_cnt", 32'(s_instr_cnt), 32'd0);
        chk("clr cycle_cnt", cycle_cnt, 32'd0);
        chk("clr instr_cnt", instr_cnt, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
